// File: rtl/tlul_arb_pkg.sv
// -----------------------------------------------------------------------------
// tlul_arb_pkg
// Constants, state encoding and source-tag helpers for tlul_host_arbiter.
//   tag_src   : shifts a host a_source left and appends the host ID in bit 0
//   untag_src : recovers the host's own source from a tagged d_source
// -----------------------------------------------------------------------------
package tlul_arb_pkg;

  localparam int NumHosts = 2;
  localparam int HostIdW  = 1;
  localparam int SrcShift = 1;
  localparam int SrcW     = 8;
  localparam int CntW     = 4;

  // Arbiter grant-lock state: FREE arbitrates each cycle, LOCKED holds the
  // grant on a host whose beat is waiting for device a_ready.
  typedef enum logic {
    ARB_FREE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // The top source bit of the host falls off the end; the caller flags that
  // case as an error but still forwards the truncated tag.
  function automatic logic [SrcW-1:0] tag_src(input logic [SrcW-1:0]    src,
                                              input logic [HostIdW-1:0] id);
    tag_src = (src << SrcShift) | SrcW'(id);
  endfunction

  function automatic logic [SrcW-1:0] untag_src(input logic [SrcW-1:0] src);
    untag_src = src >> SrcShift;
  endfunction

endpackage : tlul_arb_pkg

// File: rtl/tlul_pkg.sv
// -----------------------------------------------------------------------------
// tlul_pkg
// Minimal TileLink Uncached Lightweight (TL-UL) channel types shared by the
// host arbiter and its neighbours.
//   tl_h2d_t : host-to-device bundle (A channel request plus D channel ready)
//   tl_d2h_t : device-to-host bundle (D channel response plus A channel ready)
// -----------------------------------------------------------------------------
package tlul_pkg;

  localparam int TL_AW  = 32;  // address width
  localparam int TL_DW  = 32;  // data width
  localparam int TL_AIW = 8;   // a_source / d_source width
  localparam int TL_DIW = 1;   // d_sink width
  localparam int TL_SZW = 2;   // size field width
  localparam int TL_DBW = TL_DW / 8;

  typedef struct packed {
    logic              a_valid;
    logic [2:0]        a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic              d_valid;
    logic [2:0]        d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DIW-1:0] d_sink;
    logic [TL_DW-1:0]  d_data;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;

endpackage : tlul_pkg

// File: rtl/tlul_arb_rr2.sv
// -----------------------------------------------------------------------------
// tlul_arb_rr2
// Two-way arbiter with round-robin or fixed priority and a grant lock that
// holds the winner while its beat is back-pressured by the device.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   i_elig[1:0]    per-host eligibility (a_valid and below outstanding limit)
//   i_accept       granted beat handshaken this cycle
//   i_stall        granted beat valid but not accepted this cycle
//   o_gnt          granted host ID (meaningful when o_gnt_valid)
//   o_gnt_valid    a host is granted this cycle
//   o_lock         grant lock currently held
// -----------------------------------------------------------------------------
module tlul_arb_rr2
  import tlul_arb_pkg::*;
#(
  parameter bit FixedPrio = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] i_elig,
  input  logic       i_accept,
  input  logic       i_stall,
  output logic       o_gnt,
  output logic       o_gnt_valid,
  output logic       o_lock
);

  arb_state_e r_state;
  arb_state_e w_state_next;
  logic       r_rr;          // host that wins the next contested cycle
  logic       w_rr_next;
  logic       r_lock_id;
  logic       w_lock_id_next;
  logic       w_gnt;
  logic       w_gnt_valid;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ARB_FREE;
      r_rr      <= 1'b0;
      r_lock_id <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_rr      <= w_rr_next;
      r_lock_id <= w_lock_id_next;
    end
  end

  // Grant selection is kept in its own block so the accept/stall inputs,
  // which the top derives from this grant, do not close a loop in one process.
  always_comb begin
    w_gnt       = 1'b0;
    w_gnt_valid = 1'b0;
    if (r_state == ARB_LOCKED) begin
      w_gnt       = r_lock_id;
      w_gnt_valid = 1'b1;
    end else begin
      unique case (i_elig)
        2'b01: begin
          w_gnt       = 1'b0;
          w_gnt_valid = 1'b1;
        end
        2'b10: begin
          w_gnt       = 1'b1;
          w_gnt_valid = 1'b1;
        end
        2'b11: begin
          w_gnt       = FixedPrio ? 1'b1 : r_rr;
          w_gnt_valid = 1'b1;
        end
        default: begin
          w_gnt       = 1'b0;
          w_gnt_valid = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_rr_next      = r_rr;
    w_lock_id_next = r_lock_id;
    if (i_accept) begin
      w_state_next = ARB_FREE;
      w_rr_next    = ~w_gnt;
    end else if (i_stall && (r_state == ARB_FREE)) begin
      w_state_next   = ARB_LOCKED;
      w_lock_id_next = w_gnt;
    end
  end

  assign o_gnt       = w_gnt;
  assign o_gnt_valid = w_gnt_valid;
  assign o_lock      = (r_state == ARB_LOCKED);

endmodule : tlul_arb_rr2

// File: rtl/tlul_host_arbiter.sv
// -----------------------------------------------------------------------------
// tlul_host_arbiter
// Shares one TL-UL device port between the core instruction host (host0) and
// data host (host1). The A channel is arbitrated with a grant lock, a_source
// is tagged with the host ID in bit 0, and D responses are routed back by that
// tag. Each host may have at most MaxOutstanding unanswered requests.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   tl_h0_i/_o     host0 request in / response and a_ready out
//   tl_h1_i/_o     host1 request in / response and a_ready out
//   tl_d_o/_i      merged request to device / device response
//   busy_o         outstanding requests exist or a grant lock is held
//   err_o          pulse: a_source[7] set on an accepted beat, or a response
//                  for a host with nothing outstanding
// -----------------------------------------------------------------------------
module tlul_host_arbiter
  import tlul_pkg::*;
  import tlul_arb_pkg::*;
#(
  parameter int MaxOutstanding = 4,
  parameter bit FixedPrio      = 1'b0
) (
  input  logic    clk_i,
  input  logic    rst_i,
  input  tl_h2d_t tl_h0_i,
  output tl_d2h_t tl_h0_o,
  input  tl_h2d_t tl_h1_i,
  output tl_d2h_t tl_h1_o,
  output tl_h2d_t tl_d_o,
  input  tl_d2h_t tl_d_i,
  output logic    busy_o,
  output logic    err_o
);

  if ((MaxOutstanding < 1) || (MaxOutstanding > 15)) begin : g_bad_max
    $error("tlul_host_arbiter: MaxOutstanding must be in 1..15");
  end

  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

  tl_h2d_t       w_h2d [NumHosts];
  tl_d2h_t       w_d2h [NumHosts];
  logic [1:0]    w_elig;
  logic [1:0]    w_cnt_zero;
  logic          w_gnt;
  logic          w_gnt_valid;
  logic          w_lock;
  tl_h2d_t       w_sel;
  logic          w_sel_valid;
  logic          w_accept;
  logic          w_stall;
  logic          w_id;
  logic          w_rsp;
  logic          w_rsp_err;

  assign w_h2d[0] = tl_h0_i;
  assign w_h2d[1] = tl_h1_i;
  assign tl_h0_o  = w_d2h[0];
  assign tl_h1_o  = w_d2h[1];

  tlul_arb_rr2 #(
    .FixedPrio (FixedPrio)
  ) u_arb (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .i_elig      (w_elig),
    .i_accept    (w_accept),
    .i_stall     (w_stall),
    .o_gnt       (w_gnt),
    .o_gnt_valid (w_gnt_valid),
    .o_lock      (w_lock)
  );

  // ---------------------------------------------------------------- A channel
  assign w_sel       = w_h2d[w_gnt];
  assign w_sel_valid = w_gnt_valid & w_sel.a_valid & ~rst_i;
  assign w_accept    = w_sel_valid & tl_d_i.a_ready;
  assign w_stall     = w_sel_valid & ~tl_d_i.a_ready;

  // ---------------------------------------------------------------- D channel
  assign w_id      = tl_d_i.d_source[0];
  assign w_rsp     = tl_d_i.d_valid & w_h2d[w_id].d_ready & ~rst_i;
  assign w_rsp_err = w_rsp & w_cnt_zero[w_id];

  always_comb begin
    tl_d_o = '0;
    if (w_gnt_valid && !rst_i) begin
      tl_d_o          = w_sel;
      tl_d_o.a_source = tag_src(w_sel.a_source, w_gnt);
    end
    // d_ready follows the host the response belongs to, not the A grant.
    tl_d_o.d_ready = ~rst_i & w_h2d[w_id].d_ready;
  end

  function automatic tl_d2h_t host_rsp(input tl_d2h_t d,
                                       input logic    dv,
                                       input logic    ar);
    host_rsp          = d;
    host_rsp.d_source = untag_src(d.d_source);
    host_rsp.d_valid  = dv;
    host_rsp.a_ready  = ar;
  endfunction

  // ------------------------------------------------ per-host counters and I/O
  for (genvar gi = 0; gi < NumHosts; gi++) begin : g_host
    logic [CntW-1:0] r_cnt;
    logic            w_inc;
    logic            w_dec;

    assign w_inc = w_accept & (w_gnt == 1'(gi));
    // A response with nothing outstanding is forwarded but cannot underflow.
    assign w_dec = w_rsp & (w_id == 1'(gi)) & (r_cnt != '0);

    assign w_cnt_zero[gi] = (r_cnt == '0);
    assign w_elig[gi]     = w_h2d[gi].a_valid & (r_cnt < MaxCnt);

    assign w_d2h[gi] = host_rsp(tl_d_i,
                                tl_d_i.d_valid & (w_id == 1'(gi)) & ~rst_i,
                                w_gnt_valid & (w_gnt == 1'(gi)) &
                                  tl_d_i.a_ready & ~rst_i);

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_cnt <= '0;
      end else if (w_inc && !w_dec) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (w_dec && !w_inc) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign busy_o = ~rst_i & (~(&w_cnt_zero) | w_lock);
  assign err_o  = (w_accept & w_sel.a_source[SrcW-1]) | w_rsp_err;

endmodule : tlul_host_arbiter
